// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing checker:
//   - 640x480@60 timing constants (pixel clocks per line, sync widths, lines)
//   - TinyVGA PMOD bit positions for the sync signals
//   - FSM state type used by the checker
// -----------------------------------------------------------------------------
package vga_pkg;

  // 640x480@60 timing, one pixel per clock
  localparam int unsigned VGA_H_TOTAL = 800;
  localparam int unsigned VGA_H_SYNC  = 96;
  localparam int unsigned VGA_V_TOTAL = 525;
  localparam int unsigned VGA_V_SYNC  = 2;

  // TinyVGA PMOD bit indices (both syncs active-low)
  localparam int unsigned PMOD_HSYNC_BIT = 7;
  localparam int unsigned PMOD_VSYNC_BIT = 3;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } vga_state_e;

endpackage : vga_pkg

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchronizer followed by an edge register. Produces single-cycle
// rise/fall pulses; an edge on i_async shows up on the pulse outputs such that
// logic clocked by clk acts on it at the third rising edge after the change.
//
// Ports:
//   clk      in   pixel clock
//   rst_n    in   asynchronous active-low reset
//   i_async  in   asynchronous input level
//   o_rise   out  one-cycle pulse on a synchronized 0->1 transition
//   o_fall   out  one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module sync_edge_det #(
  // Reset level of all three flops; sync lines idle high, so resetting to 1
  // avoids a spurious edge when an idle-high input is present at reset release.
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule : sync_edge_det

// File: rtl/vga_timing_checker.sv
// -----------------------------------------------------------------------------
// vga_timing_checker
// Receive-side checker for a TinyVGA-PMOD stream. Measures HSYNC/VSYNC timing
// against the configured mode, tracks lock over consecutive good frames and
// reports sticky errors plus a saturating bad-frame count.
//
// Ports:
//   clk     in   pixel clock, one pixel per cycle
//   rst_n   in   asynchronous active-low reset
//   ui_in   in   PMOD stream: [7]=HSYNC, [3]=VSYNC (active-low), others colour
//   uo_out  out  [0]=locked, [1]=h_err, [2]=v_err, [3]=frame toggle,
//                [7:4]=bad_frames (saturating at 15); registered
//
// Build option:
//   VGA_CHK_TIMEOUT_EN  when defined, a line with no hsync fall for 2*H_TOTAL
//                       clocks drops the checker back to SEARCH and flags h_err.
// -----------------------------------------------------------------------------
module vga_timing_checker
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  localparam logic [10:0] LP_H_PERIOD = 11'(H_TOTAL - 1);
  localparam logic [10:0] LP_H_WIDTH  = 11'(H_SYNC);
  localparam logic [9:0]  LP_V_TOTAL  = 10'(V_TOTAL);
  localparam logic [9:0]  LP_V_SYNC   = 10'(V_SYNC);
  localparam logic [2:0]  LP_LOCK     = 3'(LOCK_FRAMES);

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (&v) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (&v) ? v : v + 10'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (&v) ? v : v + 4'd1;
  endfunction

  // Colour bits are not checked
  logic w_unused_colour;
  assign w_unused_colour = ^{ui_in[6:4], ui_in[2:0]};

  logic w_hrise, w_hfall, w_vrise, w_vfall;

  sync_edge_det #(.RST_VAL(1'b1)) u_hsync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ui_in[PMOD_HSYNC_BIT]),
    .o_rise  (w_hrise),
    .o_fall  (w_hfall)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_vsync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ui_in[PMOD_VSYNC_BIT]),
    .o_rise  (w_vrise),
    .o_fall  (w_vfall)
  );

  vga_state_e  r_state, w_state_nxt;
  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [2:0]  r_good_cnt, w_good_nxt;
  logic [3:0]  r_bad_frames, w_bad_nxt;
  logic        r_toggle, w_toggle_nxt;
  logic        r_h_valid, r_v_valid;
  logic        r_frame_bad;
  logic        r_h_err, r_v_err;
  logic [7:0]  r_uo_out;

  logic        w_active;
  logic [10:0] w_h_inc;
  logic [9:0]  w_v_inc;
  logic        w_h_fail, w_v_fail, w_frame_bad;
  logic        w_timeout;
  logic        w_h_hold;

  assign w_active = (r_state != ST_SEARCH);
  assign w_h_inc  = sat_inc11(r_h_cnt);

  // Line count including an hsync fall that lands in this same cycle. Vsync
  // edges from a well-formed source coincide with an hsync fall, so this is
  // the number of lines actually elapsed at the vsync edge.
  assign w_v_inc  = w_hfall ? sat_inc10(r_v_cnt) : r_v_cnt;

  // Width: the count including the rise cycle equals the low time in clocks.
  // Period: the pre-edge count is the last pixel index of the line.
  assign w_h_fail = w_active & r_h_valid &
                    ((w_hrise & (w_h_inc != LP_H_WIDTH)) |
                     (w_hfall & (r_h_cnt != LP_H_PERIOD)));

  // The frame-length check needs a full frame since the last vsync fall, so
  // it waits until one vsync fall has been seen in MEASURE/LOCKED.
  assign w_v_fail = w_active &
                    ((w_vrise & (w_v_inc != LP_V_SYNC)) |
                     (w_vfall & r_v_valid & (w_v_inc != LP_V_TOTAL)));

  // Failures in the evaluation cycle belong to the frame that is ending.
  assign w_frame_bad = r_frame_bad | w_h_fail | w_v_fail;

`ifdef VGA_CHK_TIMEOUT_EN
  localparam logic [10:0] LP_H_TIMEOUT = 11'(2 * H_TOTAL);

  logic r_h_hold;

  // Fires once per stall: r_h_hold freezes h_cnt until hsync resumes. There is
  // nothing to lose lock on while searching, so SEARCH ignores stalls.
  assign w_timeout = w_active & ~r_h_hold & ~w_hfall & (w_h_inc == LP_H_TIMEOUT);
  assign w_h_hold  = r_h_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_hold <= 1'b0;
    end else if (w_hfall) begin
      r_h_hold <= 1'b0;
    end else if (w_timeout) begin
      r_h_hold <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_h_hold  = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SEARCH;
      r_good_cnt   <= 3'd0;
      r_bad_frames <= 4'd0;
      r_toggle     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_good_cnt   <= w_good_nxt;
      r_bad_frames <= w_bad_nxt;
      r_toggle     <= w_toggle_nxt;
    end
  end

  // FSM next state: frames are judged at each vsync fall
  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good_cnt;
    w_bad_nxt    = r_bad_frames;
    w_toggle_nxt = r_toggle;
    if (w_timeout) begin
      w_state_nxt = ST_SEARCH;
      w_good_nxt  = 3'd0;
      w_bad_nxt   = sat_inc4(r_bad_frames);
    end else if (w_vfall) begin
      unique case (r_state)
        ST_SEARCH: begin
          w_state_nxt = ST_MEASURE;
          w_good_nxt  = 3'd0;
        end
        ST_MEASURE: begin
          w_toggle_nxt = ~r_toggle;
          if (w_frame_bad) begin
            w_good_nxt = 3'd0;
            w_bad_nxt  = sat_inc4(r_bad_frames);
          end else begin
            w_good_nxt = r_good_cnt + 3'd1;
            if ((r_good_cnt + 3'd1) == LP_LOCK) begin
              w_state_nxt = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          w_toggle_nxt = ~r_toggle;
          if (w_frame_bad) begin
            w_state_nxt = ST_MEASURE;
            w_good_nxt  = 3'd0;
            w_bad_nxt   = sat_inc4(r_bad_frames);
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_good_nxt  = 3'd0;
        end
      endcase
    end
  end

  // Counters, validity qualifiers and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt     <= 11'd0;
      r_v_cnt     <= 10'd0;
      r_h_valid   <= 1'b0;
      r_v_valid   <= 1'b0;
      r_frame_bad <= 1'b0;
      r_h_err     <= 1'b0;
      r_v_err     <= 1'b0;
    end else begin
      if (w_hfall) begin
        r_h_cnt <= 11'd0;
      end else if (!w_h_hold) begin
        r_h_cnt <= w_h_inc;
      end

      // Vsync clear wins over a coincident line increment
      r_v_cnt <= w_vfall ? 10'd0 : w_v_inc;

      // Qualifiers stay clear through SEARCH, including the cycle that enters
      // MEASURE, so the first measured line/frame is never judged on a
      // partial count.
      if (!w_active || w_timeout) begin
        r_h_valid <= 1'b0;
        r_v_valid <= 1'b0;
      end else begin
        if (w_hfall) r_h_valid <= 1'b1;
        if (w_vfall) r_v_valid <= 1'b1;
      end

      if (w_vfall) begin
        r_frame_bad <= 1'b0;
      end else if (w_h_fail || w_v_fail) begin
        r_frame_bad <= 1'b1;
      end

      if (w_h_fail || w_timeout) r_h_err <= 1'b1;
      if (w_v_fail)              r_v_err <= 1'b1;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo_out <= 8'h00;
    end else begin
      r_uo_out <= {r_bad_frames, r_toggle, r_v_err, r_h_err, (r_state == ST_LOCKED)};
    end
  end

  assign uo_out = r_uo_out;

endmodule : vga_timing_checker

// File: tb/tb_vga_timing_checker.sv
module tb_vga_timing_checker;

  localparam int HT = 40;
  localparam int HS = 6;
  localparam int VT = 12;
  localparam int VS = 2;

  localparam int K_IDEAL  = 0;
  localparam int K_HLONG  = 1;
  localparam int K_HW     = 2;
  localparam int K_VSW    = 3;
  localparam int K_VSHORT = 4;
  localparam int K_STALL  = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  always #5 clk = ~clk;

  vga_timing_checker #(
    .H_TOTAL     (HT),
    .H_SYNC      (HS),
    .V_TOTAL     (VT),
    .V_SYNC      (VS),
    .LOCK_FRAMES (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  typedef struct {
    int         kind;
    logic [7:0] req;
    logic [7:0] req_mid;
  } vec_t;

  vec_t       tbl[18];
  logic [7:0] exp_q[$];
  string      name_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: uo_out=0x%02h required 0x%02h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input string name, input logic [7:0] req);
    exp_q.push_back(req);
    name_q.push_back(name);
  endtask

  task automatic check_pop();
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow: uo_out=0x%02h with no expectation queued", uo_out);
    end else begin
      string      nm;
      logic [7:0] req;
      nm  = name_q.pop_front();
      req = exp_q.pop_front();
      compare(nm, uo_out, req);
    end
  endtask

  // One pixel: drive on the falling edge, colour bits random (ignored by DUT)
  task automatic drive_cycle(input logic h, input logic v);
    logic [2:0] c_lo;
    logic [2:0] c_hi;
    @(negedge clk);
    c_lo  = 3'($urandom);
    c_hi  = 3'($urandom);
    ui_in = {h, c_hi, v, c_lo};
  endtask

  // One frame starting with a coincident hsync/vsync fall; the status after
  // that vsync fall is compared early in line 0.
  task automatic drive_frame(input int kind);
    int nlines;
    int vsw;
    nlines = (kind == K_VSHORT) ? VT - 1 : VT;
    vsw    = (kind == K_VSW) ? VS + 1 : VS;
    for (int line = 0; line < nlines; line++) begin
      int len;
      int hsw;
      len = HT;
      hsw = (kind == K_HW) ? HS - 1 : HS;
      if (kind == K_HLONG && line == 3) len = HT + 1;
      if (kind == K_STALL && line == 5) len = 2 * HT + 20;
      for (int x = 0; x < len; x++) begin
        if (line == 0 && x == 8) check_pop();
        if (kind == K_STALL && line == 5 && x == 2 * HT + 10) check_pop();
        drive_cycle(x >= hsw, line >= vsw);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ui_in = 8'h88;
    repeat (5) @(negedge clk);
    compare("reset_state", uo_out, 8'h00);
    rst_n = 1'b1;
    repeat (5) drive_cycle(1'b1, 1'b1);

    // kind, status after this frame's opening vsync fall, status mid-stall
    tbl[0]  = '{K_IDEAL,  8'h00, 8'h00};
    tbl[1]  = '{K_IDEAL,  8'h08, 8'h00};
    tbl[2]  = '{K_IDEAL,  8'h01, 8'h00};
    tbl[3]  = '{K_IDEAL,  8'h09, 8'h00};
    tbl[4]  = '{K_HLONG,  8'h01, 8'h00};
    tbl[5]  = '{K_IDEAL,  8'h1A, 8'h00};
    tbl[6]  = '{K_IDEAL,  8'h12, 8'h00};
    tbl[7]  = '{K_HW,     8'h1B, 8'h00};
    tbl[8]  = '{K_IDEAL,  8'h22, 8'h00};
    tbl[9]  = '{K_IDEAL,  8'h2A, 8'h00};
    tbl[10] = '{K_VSW,    8'h23, 8'h00};
    tbl[11] = '{K_IDEAL,  8'h3E, 8'h00};
    tbl[12] = '{K_VSHORT, 8'h36, 8'h00};
    tbl[13] = '{K_IDEAL,  8'h4E, 8'h00};
    tbl[14] = '{K_IDEAL,  8'h46, 8'h00};
    tbl[15] = '{K_IDEAL,  8'h4F, 8'h00};
`ifdef VGA_CHK_TIMEOUT_EN
    tbl[16] = '{K_STALL,  8'h47, 8'h56};
    tbl[17] = '{K_IDEAL,  8'h56, 8'h00};
`else
    tbl[16] = '{K_STALL,  8'h47, 8'h47};
    tbl[17] = '{K_IDEAL,  8'h5E, 8'h00};
`endif

    for (int i = 0; i < 18; i++) begin
      push_exp($sformatf("frame%0d_start", i + 1), tbl[i].req);
      if (tbl[i].kind == K_STALL) push_exp("stall_mid", tbl[i].req_mid);
      drive_frame(tbl[i].kind);
    end

    // Mid-frame asynchronous reset
    for (int x = 0; x < 3 * HT; x++) drive_cycle(x % HT >= HS, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("rst_async", uo_out, 8'h00);
    repeat (3) drive_cycle(1'b1, 1'b1);
    rst_n = 1'b1;
    for (int x = 0; x < 2 * HT; x++) drive_cycle(x % HT >= HS, 1'b1);
    compare("rst_post", uo_out, 8'h00);

    // Twenty consecutive bad frames: bad_frames must stop at 15
    for (int k = 1; k <= 21; k++) begin
      int         b;
      logic [7:0] req;
      b   = (k - 1 > 15) ? 15 : k - 1;
      req = (k == 1) ? 8'h00 : {4'(b), 1'((k - 1) % 2), 3'b010};
      push_exp($sformatf("sat_frame%0d", k), req);
      drive_frame((k <= 20) ? K_HLONG : K_IDEAL);
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries still queued, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_vga_timing_checker
